selmux_rr: RTL

- Parametrised successor to the 2-input selection mux: CHANNELS sources of WIDTH bits feed one registered output stage with valid/ready handshakes.
- Two selection modes:
  - Round-robin mode takes one source per transfer.
  - Merge mode reproduces the selection-mux semantics: it ORs every valid source, and "none selected" yields no transfer.
- Sits between datapath producers (register file read ports, ALU, immediate unit) and a shared internal bus.

---
 rtl/selmux_rr_if.sv | 31 +++
 rtl/selmux_rr.sv | 105 ++++++++++
 2 files changed

// File: rtl/selmux_rr_if.sv
// Handshake bundle for selmux_rr: CHANNELS producer ports with valid/ready,
// the merge mode select, and one registered consumer port.
//   in_data/in_valid/in_ready : producer side, channel c at [c*WIDTH +: WIDTH]
//   merge                     : 0 = round-robin, 1 = OR-merge of valid sources
//   out_data/out_valid/grant  : registered output word, valid and source mask
//   out_ready                 : consumer accept
interface selmux_rr_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      merge;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS-1:0]       grant;

  // Environment view: drives producers, mode and consumer ready.
  modport master (
    output in_data, in_valid, merge, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  // Mux view.
  modport slave (
    input  in_data, in_valid, merge, out_ready,
    output in_ready, out_data, out_valid, grant
  );
endinterface

// File: rtl/selmux_rr.sv
// Parametrised selection mux with a single registered output stage.
// merge=0 picks one valid source per transfer in round-robin order starting at
// ptr; merge=1 ORs all valid sources into one word. Reset is synchronous,
// active-low.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : selmux_rr_if slave modport (producer and consumer handshakes)
module selmux_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  selmux_rr_if.slave  bus
);

  localparam int unsigned PTRW = $clog2(CHANNELS);

  logic [PTRW-1:0]     ptr;
  logic [WIDTH-1:0]    data_q;
  logic                valid_q;
  logic [CHANNELS-1:0] grant_q;

  logic                load_en;
  logic                found;
  logic [PTRW-1:0]     winner;
  logic [PTRW-1:0]     idx;
  logic [PTRW-1:0]     ptr_next;
  logic [CHANNELS-1:0] winner_onehot;
  logic [WIDTH-1:0]    merged;
  logic                any_valid;

  // Output register may load when empty or draining this cycle.
  assign load_en   = !valid_q || bus.out_ready;
  assign any_valid = |bus.in_valid;

  // First valid channel scanning upward from ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = PTRW'((32'(ptr) + i) % CHANNELS);
      if (!found && bus.in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign winner_onehot = CHANNELS'(1) << winner;
  assign ptr_next      = PTRW'((32'(winner) + 32'd1) % CHANNELS);

  // OR of every valid source for merge mode.
  always_comb begin
    merged = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (bus.in_valid[c]) begin
        merged = merged | bus.in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Per-channel accept; nothing is accepted during reset or backpressure.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load_en) begin
      if (bus.merge) begin
        bus.in_ready = bus.in_valid;
      end else if (found) begin
        bus.in_ready = winner_onehot;
      end
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (bus.merge && any_valid) begin
        data_q  <= merged;
        grant_q <= bus.in_valid;
        valid_q <= 1'b1;
      end else if (!bus.merge && found) begin
        data_q  <= bus.in_data[winner*WIDTH +: WIDTH];
        grant_q <= winner_onehot;
        valid_q <= 1'b1;
        ptr     <= ptr_next;
      end else begin
        // Idle: drop valid, keep the last word on the data lines.
        grant_q <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.grant     = grant_q;

endmodule
